camera_qsys_pll_reset_seq: RTL and testbench

- Reset sequencer that sits directly downstream of the system PLL in camera_qsys.
- Runs on the free-running 50 MHz reference clock and drives the PLL's reset input.
- Synchronises and qualifies the PLL lock indication, then releases NUM_RST reset outputs in a staggered order to the outclk domains' reset synchronisers.
- Detects lock timeout, retries with a fresh PLL reset, and detects loss of lock in service.

---
 rtl/camera_qsys_rst_pkg.sv | 25 ++
 rtl/camera_qsys_bit_sync.sv | 20 ++
 rtl/camera_qsys_pll_reset_seq.sv | 131 +++++++++++++
 tb/tb_camera_qsys_pll_reset_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/camera_qsys_rst_pkg.sv
// Shared types and helpers for the camera_qsys PLL reset sequencer.
package camera_qsys_rst_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN
    } rst_state_t;

    localparam logic [7:0] RETRY_MAX = 8'd255;

    // Smallest counter width covering every terminal count; never below 1 bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/camera_qsys_bit_sync.sv
// Multi-flop synchroniser for a single asynchronous level, synchronous reset to 0.
module camera_qsys_bit_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) chain <= '0;
        else     chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/camera_qsys_pll_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset, qualifies lock, then releases
// the downstream domain resets one by one; retries on timeout and recovers on loss of lock.
module camera_qsys_pll_reset_seq
    import camera_qsys_rst_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 50000,
    parameter int unsigned LOCK_STABLE    = 1024,
    parameter int unsigned NUM_RST        = 3,
    parameter int unsigned RST_STAGGER    = 64
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic [NUM_RST-1:0] rst_out,
    output logic               ready,
    output logic               lock_lost,
    output logic [7:0]         retry_cnt
);

    localparam int unsigned REL_LAST = (NUM_RST - 1) * RST_STAGGER;
    localparam int unsigned CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE, REL_LAST + 1);

    localparam logic [CW-1:0] PLL_RST_END = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_END = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_END  = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] REL_END     = CW'(REL_LAST);

    logic          locked_s;
    rst_state_t    state;
    logic [CW-1:0] cnt;
    logic          rel_hit;

    camera_qsys_bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    // Release points are cnt == i*RST_STAGGER; since bits release in order,
    // shifting a zero in from the bottom gives the staggered pattern.
    always_comb begin
        rel_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_RST; i++) begin
            if (cnt == CW'(i * RST_STAGGER)) rel_hit = 1'b1;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= PLL_RST;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            rst_out   <= '1;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
            retry_cnt <= '0;
        end else begin
            lock_lost <= 1'b0;
            if ((state == RELEASE || state == RUN) && !locked_s) begin
                state     <= PLL_RST;
                cnt       <= '0;
                pll_rst   <= 1'b1;
                rst_out   <= '1;
                ready     <= 1'b0;
                lock_lost <= 1'b1;
            end else begin
                case (state)
                    PLL_RST: begin
                        if (cnt == PLL_RST_END) begin
                            state   <= WAIT_LOCK;
                            cnt     <= '0;
                            pll_rst <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    WAIT_LOCK: begin
                        if (locked_s) begin
                            state <= STABLE;
                            cnt   <= '0;
                        end else if (cnt == TIMEOUT_END) begin
                            state   <= PLL_RST;
                            cnt     <= '0;
                            pll_rst <= 1'b1;
                            if (retry_cnt != RETRY_MAX) retry_cnt <= retry_cnt + 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    STABLE: begin
                        if (!locked_s) begin
                            state <= WAIT_LOCK;
                            cnt   <= '0;
                        end else if (cnt == STABLE_END) begin
                            state <= RELEASE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RELEASE: begin
                        if (rel_hit) rst_out <= rst_out << 1;
                        if (cnt == REL_END) begin
                            state <= RUN;
                            cnt   <= '0;
                            ready <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        rst_out <= '0;
                        ready   <= 1'b1;
                    end
                    default: begin
                        state   <= PLL_RST;
                        cnt     <= '0;
                        pll_rst <= 1'b1;
                        rst_out <= '1;
                        ready   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_camera_qsys_pll_reset_seq.sv
// Directed bench for camera_qsys_pll_reset_seq: expected values are queued when stimulus
// is applied and popped when the corresponding DUT behaviour is measured.
module tb_camera_qsys_pll_reset_seq;

    localparam int unsigned SYNC = 2;
    localparam int unsigned PRC  = 4;
    localparam int unsigned TO   = 100;
    localparam int unsigned LS   = 16;
    localparam int unsigned NR   = 3;
    localparam int unsigned STG  = 8;

    // pll_locked rise to rst_out[0] low: synchroniser + STABLE entry + LOCK_STABLE + 1
    localparam logic [15:0] LAT0       = 16'(SYNC + 1 + LS + 1);
    localparam logic [15:0] RELOCK_LAT = 16'(1 + LS + 1);

    logic          refclk = 1'b0;
    logic          rst;
    logic          pll_locked;
    logic          pll_rst;
    logic [NR-1:0] rst_out;
    logic          ready;
    logic          lock_lost;
    logic [7:0]    retry_cnt;

    camera_qsys_pll_reset_seq #(
        .SYNC_STAGES    (SYNC),
        .PLL_RST_CYCLES (PRC),
        .LOCK_TIMEOUT   (TO),
        .LOCK_STABLE    (LS),
        .NUM_RST        (NR),
        .RST_STAGGER    (STG)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .rst_out    (rst_out),
        .ready      (ready),
        .lock_lost  (lock_lost),
        .retry_cnt  (retry_cnt)
    );

    always #10 refclk = ~refclk;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   evals = 0;
    int   fails = 0;

    function automatic logic [15:0] sig(input int sel);
        case (sel)
            0:       return {15'd0, pll_rst};
            1:       return {13'd0, rst_out};
            2:       return {15'd0, ready};
            3:       return {15'd0, lock_lost};
            default: return {8'd0, retry_cnt};
        endcase
    endfunction

    task automatic expect_val(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [15:0] obs);
        exp_t e;
        evals++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty observed=%0d required=queued_entry", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) else begin
            fails++;
            $error("FAIL %s observed=%0d required=%0d", e.tag, obs, e.val);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge refclk);
    endtask

    // Counts negedges until the selected output equals v; returns budget on expiry.
    task automatic wait_val(input int sel, input logic [15:0] v, input int budget, output int n);
        n = 0;
        while (sig(sel) !== v && n < budget) begin
            @(negedge refclk);
            n++;
        end
    endtask

    initial begin
        int n;

        rst        = 1'b1;
        pll_locked = 1'b0;
        tick(5);
        expect_val("rst_pll_rst", 16'd1);   check(sig(0));
        expect_val("rst_rst_out", 16'd7);   check(sig(1));
        expect_val("rst_ready", 16'd0);     check(sig(2));
        expect_val("rst_lock_lost", 16'd0); check(sig(3));
        expect_val("rst_retry", 16'd0);     check(sig(4));
        rst = 1'b0;

        // Clean lock
        expect_val("t1_pll_rst_width", 16'(PRC));
        wait_val(0, 16'd0, 200, n); check(16'(n));
        tick(10);
        pll_locked = 1'b1;
        expect_val("t1_rel0_latency", LAT0);
        wait_val(1, 16'd6, 200, n); check(16'(n));
        expect_val("t1_ready_early", 16'd0); check(sig(2));
        expect_val("t1_rel1_gap", 16'(STG));
        wait_val(1, 16'd4, 200, n); check(16'(n));
        expect_val("t1_rel2_gap", 16'(STG));
        wait_val(1, 16'd0, 200, n); check(16'(n));
        expect_val("t1_ready", 16'd1); check(sig(2));
        expect_val("t1_retry", 16'd0); check(sig(4));

        // Loss of lock in RUN, 5-cycle drop, then relock
        pll_locked = 1'b0;
        expect_val("t4_lost_latency", 16'(SYNC + 1));
        wait_val(3, 16'd1, 50, n); check(16'(n));
        expect_val("t4_rst_out", 16'd7); check(sig(1));
        expect_val("t4_ready", 16'd0);   check(sig(2));
        expect_val("t4_pll_rst", 16'd1); check(sig(0));
        expect_val("t4_retry", 16'd0);   check(sig(4));
        tick(1);
        expect_val("t4_lost_pulse_width", 16'd0); check(sig(3));
        tick(1);
        pll_locked = 1'b1;
        expect_val("t4_pll_rst_width", 16'(PRC));
        wait_val(0, 16'd0, 50, n); check(16'(n + 2));
        expect_val("t4_relock_rel0", RELOCK_LAT);
        wait_val(1, 16'd6, 200, n); check(16'(n));
        expect_val("t4_relock_rel_all", 16'(2 * STG));
        wait_val(1, 16'd0, 200, n); check(16'(n));
        expect_val("t4_relock_ready", 16'd1); check(sig(2));

        // Timeouts with lock held low
        pll_locked = 1'b0;
        expect_val("t2_lost_latency", 16'(SYNC + 1));
        wait_val(3, 16'd1, 50, n); check(16'(n));
        expect_val("t2_pll_rst_width0", 16'(PRC));
        wait_val(0, 16'd0, 50, n); check(16'(n));
        for (int k = 1; k <= 3; k++) begin
            expect_val("t2_timeout_window", 16'(TO));
            wait_val(0, 16'd1, 300, n); check(16'(n));
            expect_val("t2_retry", 16'(k));  check(sig(4));
            expect_val("t2_rst_out", 16'd7); check(sig(1));
            expect_val("t2_pll_rst_width", 16'(PRC));
            wait_val(0, 16'd0, 50, n); check(16'(n));
        end

        // Glitchy lock: 8 high, 3 low, then high; retries untouched
        pll_locked = 1'b1;
        tick(8);
        pll_locked = 1'b0;
        tick(3);
        expect_val("t3_no_early_release", 16'd7); check(sig(1));
        pll_locked = 1'b1;
        expect_val("t3_rel0_latency", LAT0);
        wait_val(1, 16'd6, 200, n); check(16'(n));
        expect_val("t3_retry_unchanged", 16'd3); check(sig(4));

        // Reset while mid-release
        rst = 1'b1;
        tick(1);
        expect_val("t5_rst_out", 16'd7);   check(sig(1));
        expect_val("t5_pll_rst", 16'd1);   check(sig(0));
        expect_val("t5_ready", 16'd0);     check(sig(2));
        expect_val("t5_retry", 16'd0);     check(sig(4));
        expect_val("t5_lock_lost", 16'd0); check(sig(3));

        // Retry counter saturation
        pll_locked = 1'b0;
        tick(1);
        rst = 1'b0;
        for (int k = 1; k <= 260; k++) begin
            wait_val(0, 16'd0, 50, n);
            wait_val(0, 16'd1, 300, n);
            if (k == 254) begin
                expect_val("t6_retry_254", 16'd254); check(sig(4));
            end
            if (k == 255) begin
                expect_val("t6_retry_255", 16'd255); check(sig(4));
            end
        end
        expect_val("t6_retry_saturated", 16'd255); check(sig(4));
        expect_val("t6_rst_out", 16'd7);           check(sig(1));

        $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
        $finish;
    end

endmodule
